// File: rtl/mips_component_bist.sv
// Power-on self-test for the MIPS adder, data memory and instruction decoder.
// A fixed vector sequence runs after reset and leaves one sticky pass bit per unit plus done.

module bist_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    assign sum = a + b;
endmodule

module bist_datamemory #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    logic [31:0] mem [2**ADDR_WIDTH];

    // Synchronous write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

module bist_decoder (
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [31:0] simm,
    output logic [25:0] target
);
    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign simm   = {{16{instr[15]}}, instr[15:0]};
    assign target = instr[25:0];
endmodule

module mips_component_bist #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] inject_fault,
    output logic       pass_adder,
    output logic       pass_datamemory,
    output logic       pass_instructiondecode,
    output logic       done
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADD      = 3'd1,
        S_MEM_WR   = 3'd2,
        S_MEM_NOWR = 3'd3,
        S_MEM_RD   = 3'd4,
        S_DEC      = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  idx_r, idx_s;
    logic        mis_r, mis_s;
    logic        cmp_s;

    logic [31:0]           add_a_s, add_b_s, add_exp_s, add_sum_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [31:0]           mem_wdata_s, mem_exp_s, mem_rdata_s;
    logic [31:0]           dec_instr_s;
    logic [105:0]          dec_exp_s, dec_obs_s;

    logic [5:0]  dec_opcode_s, dec_funct_s;
    logic [4:0]  dec_rs_s, dec_rt_s, dec_rd_s, dec_shamt_s;
    logic [15:0] dec_imm_s;
    logic [31:0] dec_simm_s;
    logic [25:0] dec_target_s;

    bist_adder u_add (.a(add_a_s), .b(add_b_s), .sum(add_sum_s));

    bist_datamemory #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk(clk), .we(mem_we_s), .addr(mem_addr_s), .wdata(mem_wdata_s), .rdata(mem_rdata_s)
    );

    bist_decoder u_dec (
        .instr(dec_instr_s), .opcode(dec_opcode_s), .rs(dec_rs_s), .rt(dec_rt_s), .rd(dec_rd_s),
        .shamt(dec_shamt_s), .funct(dec_funct_s), .imm(dec_imm_s), .simm(dec_simm_s),
        .target(dec_target_s)
    );

    // Only MEM_WR may write; MEM_NOWR drives a decoy word with the enable low
    assign mem_we_s    = (state_r == S_MEM_WR);
    assign mem_addr_s  = {{(ADDR_WIDTH-2){1'b0}}, idx_r};
    assign mem_exp_s   = 32'hA5A5A5A0 | {30'd0, idx_r};
    assign mem_wdata_s = (state_r == S_MEM_NOWR) ? 32'hDEADBEEF : mem_exp_s;
    assign dec_obs_s   = {dec_opcode_s, dec_rs_s, dec_rt_s, dec_rd_s, dec_shamt_s, dec_funct_s,
                          dec_imm_s, dec_simm_s, dec_target_s};

    // Vector tables for the adder and decoder, selected by the vector index
    always_comb begin
        add_a_s     = 32'd0;
        add_b_s     = 32'd0;
        add_exp_s   = 32'd0;
        dec_instr_s = 32'd0;
        dec_exp_s   = 106'd0;
        case (idx_r)
            2'd0: begin
                add_a_s     = 32'd0;
                add_b_s     = 32'd0;
                add_exp_s   = 32'd0;
                dec_instr_s = 32'h012A4020;
                dec_exp_s   = {6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h4020, 32'h00004020, 26'h12A4020};
            end
            2'd1: begin
                add_a_s     = 32'd1;
                add_b_s     = 32'd1;
                add_exp_s   = 32'd2;
                dec_instr_s = 32'h8D090004;
                dec_exp_s   = {6'h23, 5'd8, 5'd9, 5'd0, 5'd0, 6'h04, 16'h0004, 32'h00000004, 26'h1090004};
            end
            2'd2: begin
                add_a_s     = 32'hFFFFFFFF;
                add_b_s     = 32'd1;
                add_exp_s   = 32'd0;
                dec_instr_s = 32'h08000010;
                dec_exp_s   = {6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h10, 16'h0010, 32'h00000010, 26'h0000010};
            end
            2'd3: begin
                add_a_s     = 32'h7FFFFFFF;
                add_b_s     = 32'd1;
                add_exp_s   = 32'h80000000;
                dec_instr_s = 32'h2108FFFF;
                dec_exp_s   = {6'h08, 5'd8, 5'd8, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 32'hFFFFFFFF, 26'h108FFFF};
            end
            default: begin
                add_exp_s = 32'd0;
            end
        endcase
    end

    // Per-cycle compare of the active unit; inject_fault flips the observed LSB
    always_comb begin
        cmp_s = 1'b0;
        case (state_r)
            S_ADD:    cmp_s = (add_sum_s ^ {31'd0, inject_fault[0]}) != add_exp_s;
            S_MEM_RD: cmp_s = (mem_rdata_s ^ {31'd0, inject_fault[1]}) != mem_exp_s;
            S_DEC:    cmp_s = (dec_obs_s ^ {105'd0, inject_fault[2]}) != dec_exp_s;
            default:  cmp_s = 1'b0;
        endcase
    end

    // Next-state sequencing; every multi-cycle phase ends when the index reaches 3
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:     state_s = S_ADD;
            S_ADD:      state_s = (idx_r == 2'd3) ? S_MEM_WR : S_ADD;
            S_MEM_WR:   state_s = (idx_r == 2'd3) ? S_MEM_NOWR : S_MEM_WR;
            S_MEM_NOWR: state_s = S_MEM_RD;
            S_MEM_RD:   state_s = (idx_r == 2'd3) ? S_DEC : S_MEM_RD;
            S_DEC:      state_s = (idx_r == 2'd3) ? S_DONE : S_DEC;
            S_DONE:     state_s = S_DONE;
            default:    state_s = S_IDLE;
        endcase
        if (state_s != state_r) begin
            idx_s = 2'd0;
            mis_s = 1'b0;
        end else begin
            idx_s = (state_r == S_DONE) ? 2'd0 : idx_r + 2'd1;
            mis_s = mis_r | cmp_s;
        end
    end

    // State, index, mismatch flag and sticky result bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r                <= S_IDLE;
            idx_r                  <= 2'd0;
            mis_r                  <= 1'b0;
            pass_adder             <= 1'b0;
            pass_datamemory        <= 1'b0;
            pass_instructiondecode <= 1'b0;
            done                   <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            mis_r   <= mis_s;
            if (idx_r == 2'd3 && !(mis_r | cmp_s)) begin
                if (state_r == S_ADD)    pass_adder             <= 1'b1;
                if (state_r == S_MEM_RD) pass_datamemory        <= 1'b1;
                if (state_r == S_DEC)    pass_instructiondecode <= 1'b1;
            end
            if (state_r == S_DEC && idx_r == 2'd3) begin
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mips_component_bist.sv
// Randomised fault-injection bench for mips_component_bist with a timeline-level reference model.

module tb_mips_component_bist;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] inject_fault = 3'd0;
    logic       pass_adder, pass_datamemory, pass_instructiondecode, done;

    int total = 0;
    int bad = 0;
    int n = 0;
    logic [2:0] hist [64];
    bit checking = 1'b0;
    bit force_flag = 1'b0;

    mips_component_bist #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .inject_fault(inject_fault),
        .pass_adder(pass_adder), .pass_datamemory(pass_datamemory),
        .pass_instructiondecode(pass_instructiondecode), .done(done)
    );

    always #5 clk = ~clk;

    // Edge counter since reset release plus the fault value seen at each edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n <= 0;
            for (int i = 0; i < 64; i++) hist[i] <= 3'd0;
        end else begin
            if (n < 62) begin
                n <= n + 1;
                hist[n + 1] <= inject_fault;
            end
        end
    end

    // Expected {pass_adder, pass_datamemory, pass_instructiondecode, done} after edge n
    function automatic logic [3:0] model_out();
        logic fa, fm, fd;
        fa = 1'b0;
        fm = force_flag;
        fd = 1'b0;
        for (int e = 2; e <= 5; e++)   fa |= hist[e][0];
        for (int e = 11; e <= 14; e++) fm |= hist[e][1];
        for (int e = 15; e <= 18; e++) fd |= hist[e][2];
        if (reset) return 4'b0000;
        return {(n >= 5) && !fa, (n >= 14) && !fm, (n >= 18) && !fd, n >= 18};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s n=%0d got=%h want=%h", name, n, got, want);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        #1;
        if (checking) begin
            check("outputs", {28'd0, pass_adder, pass_datamemory, pass_instructiondecode, done},
                  {28'd0, model_out()});
        end
    end

    task automatic start_run(input int cycles);
        reset = 1'b1;
        inject_fault = 3'd0;
        force_flag = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [2:0] pick(input int mode, input int edge_no);
        case (mode)
            1: return 3'b010;
            2: return (edge_no == 4) ? 3'b001 : 3'b000;
            3: return {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0};
            default: return 3'b000;
        endcase
    endfunction

    // Mode 4 overrides the internal write enable during the disabled-write cycle
    task automatic run_to(input int target, input int mode);
        while (n < target) begin
            inject_fault = pick(mode, n + 1);
            if (mode == 4 && n == 9) begin
                force dut.mem_we_s = 1'b1;
                force_flag = 1'b1;
            end
            @(negedge clk);
            if (mode == 4 && n == 10) begin
                release dut.mem_we_s;
                check("nowr_readback", dut.u_mem.mem[0], 32'hDEADBEEF);
            end
        end
        #2;
    endtask

    function automatic logic [31:0] outv();
        return {28'd0, pass_adder, pass_datamemory, pass_instructiondecode, done};
    endfunction

    initial begin
        @(negedge clk);
        checking = 1'b1;
        start_run(3);
        run_to(10, 0);
        check("edge10", outv(), 32'h8);
        run_to(20, 0);
        check("clean_final", outv(), 32'hF);

        start_run(2);
        run_to(20, 1);
        check("mem_fault_final", outv(), 32'hB);

        start_run(2);
        run_to(20, 2);
        check("wrap_pulse_final", outv(), 32'h7);

        start_run(2);
        run_to(12, 0);
        check("pre_reset", outv(), 32'h8);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", outv(), 32'h0);
        start_run(2);
        run_to(17, 0);
        check("edge17_restart", outv(), 32'hC);
        run_to(18, 0);
        check("restart_final", outv(), 32'hF);

        start_run(2);
        run_to(20, 4);
        check("force_we_final", outv(), 32'hB);

        for (int r = 0; r < 6; r++) begin
            start_run(2);
            run_to(22, 3);
        end

        start_run(2);
        run_to(20, 0);
        check("clean_after_random", outv(), 32'hF);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
